// File: rtl/instr_loader.sv
// instr_loader
//   Receives a framed program image as a byte stream and writes it into
//   instruction memory while holding the CPU in reset.
//   Frame: 0xA5, count N, N x 4 instruction bytes (MSB first), checksum.
//   The checksum is the XOR of the 4N instruction bytes only.
//
// Ports
//   Clock          rising-edge clock
//   Reset          asynchronous, active-low reset
//   iByte          incoming program-stream byte
//   iByteValid     iByte is valid this cycle
//   oByteReady     loader accepts a byte this cycle (low during write strobe)
//   iStart         rearm request, honoured only in DONE or ERROR
//   oWriteEnable   one-cycle instruction-memory write strobe
//   oWriteAddress  instruction-memory write address
//   oInstruction   28-bit instruction word to be written
//   oCpuReset      active-high CPU reset, released only in DONE
//   oDone          load finished with a matching checksum
//   oError         load aborted
module instr_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [7:0]            iByte,
  input  logic                  iByteValid,
  output logic                  oByteReady,
  input  logic                  iStart,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [27:0]           oInstruction,
  output logic                  oCpuReset,
  output logic                  oDone,
  output logic                  oError
);

  // Largest instruction count that still fits the address space without wrap.
  localparam int unsigned MAX_COUNT = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  state_t      state_r;
  logic [7:0]  count_r;       // N from the frame header
  logic [7:0]  instrCount_r;  // instructions already written this frame
  logic [1:0]  byteCnt_r;     // position of the next byte within an instruction
  logic [23:0] assembly_r;    // first three bytes; the fourth is merged on the fly
  logic [7:0]  checksum_r;
  logic        accept_s;

  // Upper nibble of an instruction's leading byte is reserved and must be zero.
  function automatic logic reservedBad(input logic [7:0] b);
    return (b[7:4] != 4'h0);
  endfunction

  // A byte is consumed only on a valid/ready handshake.
  always_comb begin
    accept_s = iByteValid & oByteReady;
  end

  // Frame-parsing FSM; every output is a register updated alongside the state.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r       <= IDLE;
      count_r       <= 8'd0;
      instrCount_r  <= 8'd0;
      byteCnt_r     <= 2'd0;
      assembly_r    <= 24'd0;
      checksum_r    <= 8'd0;
      oByteReady    <= 1'b0;
      oWriteEnable  <= 1'b0;
      oWriteAddress <= '0;
      oInstruction  <= 28'd0;
      oCpuReset     <= 1'b1;
      oDone         <= 1'b0;
      oError        <= 1'b0;
    end else begin
      oWriteEnable <= 1'b0;
      case (state_r)
        IDLE: begin
          // Also raises ready on the first edge after reset release.
          oByteReady <= 1'b1;
          if (accept_s && (iByte == 8'hA5)) begin
            state_r <= COUNT;
          end
        end

        COUNT: begin
          if (accept_s) begin
            if ((iByte == 8'd0) || (32'(iByte) > MAX_COUNT)) begin
              state_r    <= ERROR;
              oByteReady <= 1'b0;
              oError     <= 1'b1;
            end else begin
              state_r       <= DATA;
              count_r       <= iByte;
              instrCount_r  <= 8'd0;
              byteCnt_r     <= 2'd0;
              checksum_r    <= 8'd0;
              oWriteAddress <= '0;
            end
          end
        end

        DATA: begin
          if (oWriteEnable) begin
            // Strobe cycle just ended: advance address, decide if frame body is complete.
            oByteReady    <= 1'b1;
            oWriteAddress <= oWriteAddress + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            instrCount_r  <= instrCount_r + 8'd1;
            if ((instrCount_r + 8'd1) == count_r) begin
              state_r <= CHECK;
            end
          end else if (accept_s) begin
            if ((byteCnt_r == 2'd0) && reservedBad(iByte)) begin
              state_r    <= ERROR;
              oByteReady <= 1'b0;
              oError     <= 1'b1;
            end else begin
              assembly_r <= {assembly_r[15:0], iByte};
              checksum_r <= checksum_r ^ iByte;
              byteCnt_r  <= byteCnt_r + 2'd1;
              if (byteCnt_r == 2'd3) begin
                // Fourth byte: present the word now, stall input for the strobe cycle.
                oWriteEnable <= 1'b1;
                oInstruction <= {assembly_r[19:0], iByte};
                oByteReady   <= 1'b0;
              end
            end
          end
        end

        CHECK: begin
          if (accept_s) begin
            oByteReady <= 1'b0;
            if (iByte == checksum_r) begin
              state_r   <= DONE;
              oDone     <= 1'b1;
              oCpuReset <= 1'b0;
            end else begin
              state_r <= ERROR;
              oError  <= 1'b1;
            end
          end
        end

        DONE, ERROR: begin
          if (iStart) begin
            state_r    <= IDLE;
            oByteReady <= 1'b1;
            oCpuReset  <= 1'b1;
            oDone      <= 1'b0;
            oError     <= 1'b0;
          end
        end

        default: begin
          state_r    <= IDLE;
          oByteReady <= 1'b0;
          oCpuReset  <= 1'b1;
          oDone      <= 1'b0;
          oError     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  localparam int AW = 8;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic [7:0]    iByte = 8'h00;
  logic          iByteValid = 1'b0;
  logic          iStart = 1'b0;
  logic          oByteReady;
  logic          oWriteEnable;
  logic [AW-1:0] oWriteAddress;
  logic [27:0]   oInstruction;
  logic          oCpuReset;
  logic          oDone;
  logic          oError;

  int nCompared = 0;
  int nMismatch = 0;

  logic [AW-1:0] wrAddr[$];
  logic [27:0]   wrData[$];

  instr_loader #(.ADDR_WIDTH(AW)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .iByte(iByte),
    .iByteValid(iByteValid),
    .oByteReady(oByteReady),
    .iStart(iStart),
    .oWriteEnable(oWriteEnable),
    .oWriteAddress(oWriteAddress),
    .oInstruction(oInstruction),
    .oCpuReset(oCpuReset),
    .oDone(oDone),
    .oError(oError)
  );

  always #5 Clock = ~Clock;

  // Record every write strobe seen at a clock edge.
  always @(posedge Clock) begin
    if (Reset && oWriteEnable) begin
      wrAddr.push_back(oWriteAddress);
      wrData.push_back(oInstruction);
    end
  end

  typedef struct {
    logic [7:0]  b;
    logic        v;
    logic        st;
    logic        r;
    logic        we;
    logic [7:0]  a;
    logic [27:0] ins;
    logic        d;
    logic        e;
    logic        c;
  } vec_t;

  vec_t tbl[16];

  logic [7:0] goodFrame[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outVec();
    return {23'd0, oByteReady, oWriteEnable, oWriteAddress, oInstruction, oDone, oError, oCpuReset};
  endfunction

  function automatic logic [63:0] mkVec(input logic r, input logic we, input logic [7:0] a,
                                        input logic [27:0] ins, input logic d, input logic e,
                                        input logic c);
    return {23'd0, r, we, a, ins, d, e, c};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic sendByte(input logic [7:0] b);
    int n;
    n = 0;
    iByte = b;
    iByteValid = 1'b1;
    while (!oByteReady && n < 20) begin
      @(negedge Clock);
      n++;
    end
    if (!oByteReady) begin
      nCompared++;
      nMismatch++;
      $display("FAIL sendByte_timeout: ready=%0b required 1 for byte %h", oByteReady, b);
    end
    @(negedge Clock);
    iByteValid = 1'b0;
  endtask

  task automatic rearm();
    iStart = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cs;
    logic [7:0] b0, b1, b2, b3;
    int bad;

    goodFrame = '{8'hA5, 8'h02, 8'h07, 8'h00, 8'h00, 8'h01,
                  8'h01, 8'h02, 8'h03, 8'h04, 8'h02, 8'h00, 8'h00};

    //        byte   v     start  ready we    addr   instr        done  err   cpuRst
    tbl[0]  = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 28'h0000000, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 28'h0000000, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 28'h0000000, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 28'h0000000, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 28'h0000000, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 28'h0000000, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 28'h0000000, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 28'h7000001, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 28'h7000001, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 28'h7000001, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 28'h7000001, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 28'h7000001, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{8'h04, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 28'h1020304, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 8'h02, 28'h1020304, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 28'h1020304, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h02, 28'h1020304, 1'b0, 1'b0, 1'b1};

    // Reset state and ready rising on the first edge after release.
    repeat (3) @(negedge Clock);
    check("reset_state", outVec(), mkVec(1'b0, 1'b0, 8'h00, 28'h0, 1'b0, 1'b0, 1'b1));
    Reset = 1'b1;
    #1;
    check("ready_before_edge", {63'd0, oByteReady}, 64'd0);
    @(negedge Clock);
    check("ready_after_release", {63'd0, oByteReady}, 64'd1);

    // Good load with noise and iByteValid held high, cycle by cycle.
    for (int i = 0; i < 16; i++) begin
      iByte = tbl[i].b;
      iByteValid = tbl[i].v;
      iStart = tbl[i].st;
      @(negedge Clock);
      check($sformatf("vec%0d", i), outVec(),
            mkVec(tbl[i].r, tbl[i].we, tbl[i].a, tbl[i].ins, tbl[i].d, tbl[i].e, tbl[i].c));
    end
    iStart = 1'b0;
    iByteValid = 1'b0;
    check("vec_write_count", 64'(wrAddr.size()), 64'd2);

    // Bad checksum: two writes, then ERROR with CPU held and input stalled.
    wrAddr.delete();
    wrData.delete();
    for (int i = 0; i < 10; i++) sendByte(goodFrame[i]);
    sendByte(8'h03);
    check("badcs_writes", {wrAddr.size() == 2, wrData[0], wrData[1]},
          {1'b1, 28'h7000001, 28'h1020304});
    check("badcs_flags", {61'd0, oError, oCpuReset, oByteReady}, {61'd0, 1'b1, 1'b1, 1'b0});
    rearm();
    check("badcs_rearm", {61'd0, oError, oCpuReset, oByteReady}, {61'd0, 1'b0, 1'b1, 1'b1});

    // Reserved-bit violation on first instruction byte.
    wrAddr.delete();
    wrData.delete();
    sendByte(8'hA5);
    sendByte(8'h01);
    sendByte(8'h17);
    check("rsvd_error", {62'd0, oError, oByteReady}, {62'd0, 1'b1, 1'b0});
    repeat (3) @(negedge Clock);
    check("rsvd_no_write", 64'(wrAddr.size()), 64'd0);
    rearm();

    // Count of zero is rejected.
    sendByte(8'hA5);
    sendByte(8'h00);
    check("count0_error", {62'd0, oError, oDone}, {62'd0, 1'b1, 1'b0});
    rearm();

    // Maximum count: 255 instructions, last write at 0xFE.
    wrAddr.delete();
    wrData.delete();
    cs = 8'h00;
    sendByte(8'hA5);
    sendByte(8'hFF);
    for (int i = 0; i < 255; i++) begin
      b0 = 8'(i & 15);
      b1 = 8'(i);
      b2 = 8'h5A;
      b3 = ~8'(i);
      cs = cs ^ b0 ^ b1 ^ b2 ^ b3;
      sendByte(b0);
      sendByte(b1);
      sendByte(b2);
      sendByte(b3);
    end
    sendByte(cs);
    check("max_done", {62'd0, oDone, oCpuReset}, {62'd0, 1'b1, 1'b0});
    check("max_count", 64'(wrAddr.size()), 64'd255);
    if (wrAddr.size() == 255) begin
      check("max_last_addr", 64'(wrAddr[254]), 64'hFE);
      bad = 0;
      for (int i = 0; i < 255; i++) begin
        b0 = 8'(i & 15);
        b1 = 8'(i);
        b3 = ~8'(i);
        if (wrAddr[i] !== 8'(i) || wrData[i] !== {b0[3:0], b1, 8'h5A, b3}) bad++;
      end
      check("max_contents", 64'(bad), 64'd0);
    end
    rearm();

    // Reset mid-frame, then a good frame, then rearm from DONE.
    wrAddr.delete();
    wrData.delete();
    sendByte(8'hA5);
    sendByte(8'h02);
    sendByte(8'h07);
    sendByte(8'h00);
    #2;
    Reset = 1'b0;
    #1;
    check("midreset_outputs", outVec(), mkVec(1'b0, 1'b0, 8'h00, 28'h0, 1'b0, 1'b0, 1'b1));
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check("midreset_no_write", 64'(wrAddr.size()), 64'd0);
    for (int i = 0; i < 11; i++) sendByte(goodFrame[i]);
    check("reload_writes", {wrAddr.size() == 2, wrAddr[0], wrData[0], wrAddr[1], wrData[1]},
          {1'b1, 8'h00, 28'h7000001, 8'h01, 28'h1020304});
    check("reload_done", {62'd0, oDone, oCpuReset}, {62'd0, 1'b1, 1'b0});
    rearm();
    check("rearm_idle", {60'd0, oDone, oError, oCpuReset, oByteReady},
          {60'd0, 1'b0, 1'b0, 1'b1, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
